dtw_result_scan: RTL and testbench
==================================

Name: dtw_result_scan

Overview:
- Downstream stage of dtw_core: drains the 32-bit cost words dtw_core writes into its sink FIFO, one word per reference position, and finds the best alignment of the read.
- Tracks the minimum cost and its reference index, plus the second-best cost, and makes the read-until match/reject decision against a programmable threshold.
- Presents one result record per run via a valid/ready handshake to the host-facing register block.

Parameters:
- DWIDTH, 32, width of cost words read from the FIFO.
- IDX_W, 15, width of the reference index; must cover REF_SIZE.
- REF_SIZE, 29898, maximum legal ref_len; larger values are clamped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle (or longer) request to begin a scan; sampled only in IDLE
- ref_len  in  32  number of cost words to consume; latched at start
- threshold  in  DWIDTH  match threshold; latched at start
- src_fifo_rden  out  1  FIFO read enable
- src_fifo_empty  in  1  FIFO empty flag
- src_fifo_data  in  DWIDTH  FIFO read data, valid the cycle after rden
- busy  out  1  high from the start acceptance through the DONE state
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts the record
- best_cost  out  DWIDTH  minimum cost seen
- best_idx  out  IDX_W  index of the minimum cost
- second_cost  out  DWIDTH  second-smallest cost seen
- match  out  1  1 when best_cost < threshold

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - All outputs 0, except best_cost and second_cost, which reset to all-ones.
  - Counters cleared.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - On start, latch len = min(ref_len, REF_SIZE) and latch threshold.
  - Load best_cost and second_cost with all-ones, best_idx=0, issue and recv counters=0.
  - Set busy=1 and go to RUN.
  - If len==0, go directly to DONE with the all-ones results and match=0.
- RUN:
  - src_fifo_rden = !src_fifo_empty && issue_cnt < len, and is combinational on state, empty and the counter.
  - issue_cnt increments on each rden.
  - When issue_cnt reaches len on a read, go to DRAIN.
- Data capture:
  - rden_d is rden delayed one cycle.
  - On rden_d, sample src_fifo_data as c at index recv_cnt, then increment recv_cnt.
  - If c < best: second = best, best = c, best_idx = recv_cnt.
  - Else if c < second: second = c.
  - The comparison is strictly-less, so on ties the first (lowest) index wins, and an equal duplicate of best updates second.
  - Comparisons are unsigned, full DWIDTH.
- DRAIN: wait until recv_cnt == len, which is exactly one cycle after the last read. Then compute match = best_cost < latched threshold and go to DONE.
- DONE:
  - res_valid=1, and the result outputs are held stable.
  - On res_valid && res_ready, go to IDLE in the same cycle, clear res_valid and busy next cycle. Result values persist until the next start.
- start is ignored in RUN, DRAIN and DONE.
- src_fifo_empty may toggle at any cycle; the read pauses without loss, and no rden is issued while empty.
- ref_len > REF_SIZE is clamped to REF_SIZE; the remaining FIFO words are left unread.
- Reset mid-run: return immediately to IDLE with the reset values; the FIFO contents are left untouched.
- Latency: the last FIFO read to res_valid is 2 cycles; the result is ready after len + stall cycles + 2.

Decomposition:
- Shared package dtw_pkg holds:
  - DTW_DWIDTH=32 and REF_SIZE=29898
  - the state encoding (IDLE, RUN, DRAIN, DONE as a 2-bit enum)
  - COST_MAX (all-ones)
- One natural sub-module is dtw_min2_update, the combinational best/second/index update cell, so it can be reused by a future multi-lane scan.

Test Plan:
- ref_len=5, FIFO costs 40,17,90,17,3, threshold=10, empty always 0:
  - rden is high for exactly 5 cycles.
  - res_valid goes high 2 cycles after the last rden, with best_cost=3, best_idx=4, second_cost=17, match=1.
- Tie handling, costs 8,8,9 with threshold=8 -> best_cost=8, best_idx=0, second_cost=8, match=0 (not strictly less).
- Empty asserted for 1 of every 6 cycles, ref_len=100, cost[i]=1000-i:
  - rden is never high while empty, and exactly 100 reads occur.
  - best_idx=99, best_cost=901, second_cost=902.
- ref_len=0, then start -> DONE on the next cycle, best_cost=0xFFFFFFFF, match=0, and no rden ever issued.
- Backpressure: hold res_ready=0 for 20 cycles in DONE:
  - res_valid and all results stay stable, and a start pulse during DONE is ignored.
  - Asserting res_ready returns the block to IDLE and busy falls.
- Assert rst for 1 cycle at read 50 of 100:
  - All outputs return to reset values asynchronously and the state is IDLE.
  - A new start with ref_len=3 and costs 5,6,7 gives best_cost=5, best_idx=0, second_cost=6.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared constants and state encoding for the DTW result path.
package dtw_pkg;

  localparam int unsigned DTW_DWIDTH = 32;
  localparam int unsigned DTW_IDX_W  = 15;
  localparam int unsigned REF_SIZE   = 29898;

  localparam logic [DTW_DWIDTH-1:0] COST_MAX = {DTW_DWIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage : dtw_pkg

// File: rtl/dtw_min2_update.sv
// Combinational best/second/index update for one incoming cost word.
module dtw_min2_update #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned IDX_W  = 15
) (
  input  logic [DWIDTH-1:0] cost,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DWIDTH-1:0] cur_best,
  input  logic [IDX_W-1:0]  cur_best_idx,
  input  logic [DWIDTH-1:0] cur_second,
  output logic [DWIDTH-1:0] new_best,
  output logic [IDX_W-1:0]  new_best_idx,
  output logic [DWIDTH-1:0] new_second
);

  // Strict-less compare keeps the lowest index on ties; an equal copy of best lands in second.
  always_comb begin
    new_best     = cur_best;
    new_best_idx = cur_best_idx;
    new_second   = cur_second;
    if (cost < cur_best) begin
      new_second   = cur_best;
      new_best     = cost;
      new_best_idx = idx;
    end else if (cost < cur_second) begin
      new_second   = cost;
    end
  end

endmodule : dtw_min2_update

// File: rtl/dtw_result_scan.sv
// Drains dtw_core cost words, tracks best/second cost and index, issues match decision.
module dtw_result_scan #(
  parameter int unsigned DWIDTH   = dtw_pkg::DTW_DWIDTH,
  parameter int unsigned IDX_W    = dtw_pkg::DTW_IDX_W,
  parameter int unsigned REF_SIZE = dtw_pkg::REF_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ref_len,
  input  logic [DWIDTH-1:0] threshold,
  output logic              src_fifo_rden,
  input  logic              src_fifo_empty,
  input  logic [DWIDTH-1:0] src_fifo_data,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] best_cost,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DWIDTH-1:0] second_cost,
  output logic              match
);

  import dtw_pkg::*;

  localparam logic [DWIDTH-1:0] COST_ONES = {DWIDTH{1'b1}};

  scan_state_t       state, state_nxt;
  logic [IDX_W-1:0]  len_q, len_nxt;
  logic [DWIDTH-1:0] thr_q, thr_nxt;
  logic [IDX_W-1:0]  issue_cnt, issue_nxt;
  logic [IDX_W-1:0]  recv_cnt, recv_nxt;
  logic [DWIDTH-1:0] best_q, best_nxt;
  logic [DWIDTH-1:0] second_q, second_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic              match_q, match_nxt;
  logic              busy_q, busy_nxt;
  logic              valid_q, valid_nxt;
  logic              rden_d, rden_c;
  logic [IDX_W-1:0]  len_clamp_c;
  logic [DWIDTH-1:0] upd_best, upd_second;
  logic [IDX_W-1:0]  upd_idx;

  // Requested length clamped to the largest legal reference.
  assign len_clamp_c = (ref_len > 32'(REF_SIZE)) ? IDX_W'(REF_SIZE) : IDX_W'(ref_len);

  dtw_min2_update #(
    .DWIDTH (DWIDTH),
    .IDX_W  (IDX_W)
  ) u_min2 (
    .cost         (src_fifo_data),
    .idx          (recv_cnt),
    .cur_best     (best_q),
    .cur_best_idx (idx_q),
    .cur_second   (second_q),
    .new_best     (upd_best),
    .new_best_idx (upd_idx),
    .new_second   (upd_second)
  );

  // Next-state, read issue, data capture and result logic.
  always_comb begin
    state_nxt  = state;
    len_nxt    = len_q;
    thr_nxt    = thr_q;
    issue_nxt  = issue_cnt;
    recv_nxt   = recv_cnt;
    best_nxt   = best_q;
    second_nxt = second_q;
    idx_nxt    = idx_q;
    match_nxt  = match_q;
    busy_nxt   = busy_q;
    valid_nxt  = valid_q;
    rden_c     = 1'b0;

    // Word read last cycle is on the FIFO data bus now.
    if (rden_d) begin
      best_nxt   = upd_best;
      second_nxt = upd_second;
      idx_nxt    = upd_idx;
      recv_nxt   = recv_cnt + IDX_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          len_nxt    = len_clamp_c;
          thr_nxt    = threshold;
          best_nxt   = COST_ONES;
          second_nxt = COST_ONES;
          idx_nxt    = '0;
          match_nxt  = 1'b0;
          issue_nxt  = '0;
          recv_nxt   = '0;
          busy_nxt   = 1'b1;
          if (len_clamp_c == '0) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        rden_c = !src_fifo_empty && (issue_cnt < len_q);
        if (rden_c) begin
          issue_nxt = issue_cnt + IDX_W'(1);
          if ((issue_cnt + IDX_W'(1)) == len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Last word is captured this cycle; decide on the updated best.
        if (recv_nxt == len_q) begin
          match_nxt = best_nxt < thr_q;
          valid_nxt = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (valid_q && res_ready) begin
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      thr_q     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      best_q    <= COST_ONES;
      second_q  <= COST_ONES;
      idx_q     <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      rden_d    <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      thr_q     <= thr_nxt;
      issue_cnt <= issue_nxt;
      recv_cnt  <= recv_nxt;
      best_q    <= best_nxt;
      second_q  <= second_nxt;
      idx_q     <= idx_nxt;
      match_q   <= match_nxt;
      busy_q    <= busy_nxt;
      valid_q   <= valid_nxt;
      rden_d    <= rden_c;
    end
  end

  assign src_fifo_rden = rden_c;
  assign busy          = busy_q;
  assign res_valid     = valid_q;
  assign best_cost     = best_q;
  assign best_idx      = idx_q;
  assign second_cost   = second_q;
  assign match         = match_q;

endmodule : dtw_result_scan

// File: tb/tb_dtw_result_scan.sv
// Directed bench for dtw_result_scan with a simple FIFO model.
module tb_dtw_result_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ref_len;
  logic [31:0] threshold;
  logic        src_fifo_rden;
  logic        src_fifo_empty;
  logic [31:0] src_fifo_data;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] best_cost;
  logic [14:0] best_idx;
  logic [31:0] second_cost;
  logic        match;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          last_rd_cyc = 0;
  int          viol = 0;
  int          start_cyc = 0;
  int          valid_cyc = 0;
  bit          empty_mode = 1'b0;
  bit          pop_pending = 1'b0;
  logic [31:0] fifo_q[$];

  dtw_result_scan dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ref_len        (ref_len),
    .threshold      (threshold),
    .src_fifo_rden  (src_fifo_rden),
    .src_fifo_empty (src_fifo_empty),
    .src_fifo_data  (src_fifo_data),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .best_cost      (best_cost),
    .best_idx       (best_idx),
    .second_cost    (second_cost),
    .match          (match)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read data appears the cycle after rden.
  initial src_fifo_data = '0;
  always @(posedge clk) begin
    if (pop_pending && fifo_q.size() > 0) src_fifo_data <= fifo_q.pop_front();
  end

  // Empty flag: FIFO exhausted, or the 1-in-6 stall pattern.
  initial src_fifo_empty = 1'b1;
  always @(negedge clk) begin
    #1;
    src_fifo_empty = (fifo_q.size() == 0) || (empty_mode && (cyc % 6 == 5));
  end

  // Read monitor, sampled well after the flag and state have settled.
  always @(negedge clk) begin
    #3;
    pop_pending = src_fifo_rden;
    if (src_fifo_rden) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (src_fifo_empty) viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_scan(input logic [31:0] len, input logic [31:0] thr);
    int n;
    @(negedge clk);
    start = 1'b1; ref_len = len; threshold = thr; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 64'(res_valid), 64'd1);
    valid_cyc = cyc;
  endtask

  task automatic accept;
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_clear", 64'(res_valid), 64'd0);
    check("busy_clear",  64'(busy),      64'd0);
  endtask

  initial begin
    int rd0, chg, n;
    logic [31:0] c;
    rst = 1'b1; start = 1'b0; ref_len = '0; threshold = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_best",   64'(best_cost),   64'hFFFF_FFFF);
    check("rst_second", 64'(second_cost), 64'hFFFF_FFFF);
    check("rst_idx",    64'(best_idx),    64'd0);
    check("rst_valid",  64'(res_valid),   64'd0);
    check("rst_busy",   64'(busy),        64'd0);
    check("rst_match",  64'(match),       64'd0);
    check("rst_rden",   64'(src_fifo_rden), 64'd0);
    rst = 1'b0;

    // Basic scan
    fifo_q = {32'd40, 32'd17, 32'd90, 32'd17, 32'd3};
    rd0 = rd_cnt;
    run_scan(32'd5, 32'd10);
    check("t1_reads",   64'(rd_cnt - rd0), 64'd5);
    check("t1_latency", 64'(valid_cyc - last_rd_cyc), 64'd2);
    check("t1_best",    64'(best_cost),   64'd3);
    check("t1_idx",     64'(best_idx),    64'd4);
    check("t1_second",  64'(second_cost), 64'd17);
    check("t1_match",   64'(match),       64'd1);
    check("t1_busy",    64'(busy),        64'd1);
    accept();

    // Ties
    fifo_q = {32'd8, 32'd8, 32'd9};
    run_scan(32'd3, 32'd8);
    check("t2_best",   64'(best_cost),   64'd8);
    check("t2_idx",    64'(best_idx),    64'd0);
    check("t2_second", 64'(second_cost), 64'd8);
    check("t2_match",  64'(match),       64'd0);
    accept();

    // Stalled FIFO, descending costs
    fifo_q = {};
    for (int i = 0; i < 100; i++) begin
      c = 32'(1000 - i);
      fifo_q.push_back(c);
    end
    empty_mode = 1'b1;
    rd0 = rd_cnt; viol = 0;
    run_scan(32'd100, 32'd902);
    empty_mode = 1'b0;
    check("t3_reads",  64'(rd_cnt - rd0), 64'd100);
    check("t3_noempty_rd", 64'(viol),     64'd0);
    check("t3_best",   64'(best_cost),   64'd901);
    check("t3_idx",    64'(best_idx),    64'd99);
    check("t3_second", 64'(second_cost), 64'd902);
    check("t3_match",  64'(match),       64'd1);
    accept();

    // Zero length
    fifo_q = {32'd1, 32'd2};
    rd0 = rd_cnt;
    run_scan(32'd0, 32'd100);
    check("t4_done_next", 64'(valid_cyc - start_cyc), 64'd1);
    check("t4_best",   64'(best_cost),   64'hFFFF_FFFF);
    check("t4_second", 64'(second_cost), 64'hFFFF_FFFF);
    check("t4_match",  64'(match),       64'd0);
    check("t4_reads",  64'(rd_cnt - rd0), 64'd0);
    accept();

    // Backpressure in DONE, with an ignored start
    fifo_q = {32'd50, 32'd20, 32'd30};
    run_scan(32'd3, 32'd25);
    fifo_q.push_back(32'd1);
    fifo_q.push_back(32'd1);
    rd0 = rd_cnt; chg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) begin start = 1'b1; ref_len = 32'd2; threshold = 32'd99; end
      if (i == 6) start = 1'b0;
      if (res_valid !== 1'b1 || busy !== 1'b1 || best_cost !== 32'd20 || best_idx !== 15'd1 ||
          second_cost !== 32'd30 || match !== 1'b1) chg++;
    end
    check("t5_stable", 64'(chg), 64'd0);
    check("t5_no_rd",  64'(rd_cnt - rd0), 64'd0);
    accept();
    check("t5_persist_best", 64'(best_cost), 64'd20);
    check("t5_persist_idx",  64'(best_idx),  64'd1);

    // Reset mid-run
    fifo_q = {};
    for (int i = 0; i < 100; i++) begin
      c = 32'(200 + i);
      fifo_q.push_back(c);
    end
    rd0 = rd_cnt;
    @(negedge clk);
    start = 1'b1; ref_len = 32'd100; threshold = 32'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((rd_cnt - rd0) < 50 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach50", 64'(rd_cnt - rd0), 64'd50);
    rst = 1'b1;
    #1;
    check("t6_best",   64'(best_cost),     64'hFFFF_FFFF);
    check("t6_second", 64'(second_cost),   64'hFFFF_FFFF);
    check("t6_idx",    64'(best_idx),      64'd0);
    check("t6_busy",   64'(busy),          64'd0);
    check("t6_valid",  64'(res_valid),     64'd0);
    check("t6_rden",   64'(src_fifo_rden), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fifo_q = {32'd5, 32'd6, 32'd7};
    run_scan(32'd3, 32'd0);
    check("t6_new_best",   64'(best_cost),   64'd5);
    check("t6_new_idx",    64'(best_idx),    64'd0);
    check("t6_new_second", 64'(second_cost), 64'd6);
    check("t6_new_match",  64'(match),       64'd0);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dtw_result_scan
